// File: rtl/board_io_conditioner.sv
// board_io_conditioner: syncs/debounces switches and buttons, stretches CPU reset, drives LEDs; MFP_LED_PWM_EN adds LED dimming
module board_io_conditioner #(
  parameter int N_SW          = 18,
  parameter int N_PB          = 4,
  parameter int N_LED         = 18,
  parameter int SYNC_STAGES   = 2,
  parameter int TICK_DIV      = 50000,
  parameter int DB_TICKS      = 10,
  parameter int PB_ACTIVE_LOW = 1,
  parameter int POR_TICKS     = 20
) (
  input  logic             SI_ClkIn,
  input  logic             SI_Reset,
  input  logic [N_SW-1:0]  SW_raw,
  input  logic [N_PB-1:0]  KEY_raw,
  input  logic [N_LED-1:0] IO_LED_in,
`ifdef MFP_LED_PWM_EN
  input  logic [3:0]       LED_Bright,
`endif
  output logic [N_SW-1:0]  IO_Switch,
  output logic [N_PB-1:0]  IO_PB,
  output logic [N_PB-1:0]  PB_Press,
  output logic [N_PB-1:0]  PB_Release,
  output logic [N_LED-1:0] LEDR,
  output logic             CPU_Reset_N
);
  localparam int N_IN = N_SW + N_PB;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DB_TICKS + 1);
  localparam int RW = $clog2(POR_TICKS + 1);
  localparam logic [1:0] POR = 2'd0, RUN = 2'd1, HOLD = 2'd2;
  logic [N_IN-1:0] sync_q [SYNC_STAGES];
  logic [N_IN-1:0] raw, synced, db;
  logic [DW-1:0] db_cnt [N_IN];
  logic [PW-1:0] pre_cnt;
  logic tick;
  logic [N_PB-1:0] pb_d;
  logic [1:0] state, state_nxt;
  logic [RW-1:0] por_cnt;
  // switches and buttons share one synchroniser/debounce path; buttons occupy the top bits
  assign raw = {(PB_ACTIVE_LOW != 0) ? ~KEY_raw : KEY_raw, SW_raw};
  assign synced = sync_q[SYNC_STAGES-1];
  assign tick = pre_cnt == PW'(TICK_DIV - 1);
  assign IO_Switch = db[N_SW-1:0];
  assign IO_PB = db[N_IN-1:N_SW];
  always_ff @(posedge SI_ClkIn or posedge SI_Reset)
    if (SI_Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pre_cnt <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  // a bit flips on the DB_TICKS-th consecutive mismatching tick; any agreement restarts the count
  always_ff @(posedge SI_ClkIn or posedge SI_Reset)
    if (SI_Reset) begin
      for (int i = 0; i < N_IN; i++) db_cnt[i] <= '0;
      db <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (synced[i] == db[i]) db_cnt[i] <= '0;
        else if (tick) begin
          db_cnt[i] <= (db_cnt[i] == DW'(DB_TICKS - 1)) ? '0 : db_cnt[i] + 1'b1;
          if (db_cnt[i] == DW'(DB_TICKS - 1)) db[i] <= ~db[i];
        end
    end
  always_ff @(posedge SI_ClkIn or posedge SI_Reset)
    if (SI_Reset) begin
      pb_d <= '0;
      PB_Press <= '0;
      PB_Release <= '0;
    end else begin
      pb_d <= IO_PB;
      PB_Press <= IO_PB & ~pb_d;
      PB_Release <= ~IO_PB & pb_d;
    end
  assign state_nxt = (state == POR) ? ((tick && por_cnt == RW'(POR_TICKS - 1)) ? RUN : POR) :
                     IO_PB[0] ? HOLD : (state == RUN) ? RUN : POR;
  // CPU_Reset_N is taken from the next state so it changes together with the FSM
  always_ff @(posedge SI_ClkIn or posedge SI_Reset)
    if (SI_Reset) begin
      state <= POR;
      por_cnt <= '0;
      CPU_Reset_N <= 1'b0;
    end else begin
      state <= state_nxt;
      por_cnt <= (state == POR && state_nxt == POR) ? por_cnt + RW'(tick) : '0;
      CPU_Reset_N <= state_nxt == RUN;
    end
`ifdef MFP_LED_PWM_EN
  logic [N_LED-1:0] led_q;
  logic [3:0] pwm_cnt;
  always_ff @(posedge SI_ClkIn or posedge SI_Reset)
    if (SI_Reset) begin
      led_q <= '0;
      pwm_cnt <= '0;
    end else begin
      led_q <= IO_LED_in;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  assign LEDR = led_q & {N_LED{pwm_cnt < LED_Bright}};
`else
  always_ff @(posedge SI_ClkIn or posedge SI_Reset)
    if (SI_Reset) LEDR <= '0;
    else LEDR <= IO_LED_in;
`endif
endmodule

// File: doc/board_io_conditioner.md
Name: board_io_conditioner

Overview:
- Parametrised conditioning stage between raw board I/O (slide switches, pushbuttons, LEDs) and the mfp_sys GPIO ports.
- Input conditioning:
  - synchronises every input;
  - debounces every input;
  - normalises pushbutton polarity to active-high;
  - emits one-cycle press and release pulses.
- Reset generation: drives an active-low CPU reset, stretched at power-up and held while PB[0] is held.
- Registers LED outputs.

Parameters:
- N_SW, 18, number of slide switches.
- N_PB, 4, number of pushbuttons.
- N_LED, 18, number of LEDs.
- SYNC_STAGES, 2, synchroniser flops per input; minimum 2.
- TICK_DIV, 50000, clock cycles per debounce tick (1 ms at 50 MHz).
- DB_TICKS, 10, consecutive mismatching ticks required before a debounced bit changes.
- PB_ACTIVE_LOW, 1, raw pushbuttons read 0 when pressed.
- POR_TICKS, 20, ticks CPU_Reset_N is held low after SI_Reset deasserts.

Ports:
- SI_ClkIn  in  1  single system clock.
- SI_Reset  in  1  asynchronous, active-high reset.
- SW_raw  in  N_SW  raw slide switches.
- KEY_raw  in  N_PB  raw pushbuttons.
- IO_LED_in  in  N_LED  LED values from mfp_sys.
- IO_Switch  out  N_SW  debounced switches.
- IO_PB  out  N_PB  debounced pushbuttons; 1 = pressed.
- PB_Press  out  N_PB  one-cycle pulse on debounced press.
- PB_Release  out  N_PB  one-cycle pulse on debounced release.
- LEDR  out  N_LED  registered LED drive.
- CPU_Reset_N  out  1  to mfp_sys SI_Reset_N; 0 = reset.

Behaviour:
- Reset values (all asynchronous on SI_Reset = 1):
  - synchroniser flops, prescaler and debounce counters = 0;
  - IO_Switch = 0, IO_PB = 0, PB_Press = 0, PB_Release = 0;
  - LEDR = 0, CPU_Reset_N = 0.
- Synchronisers:
  - each raw bit passes through SYNC_STAGES flops;
  - KEY_raw is inverted before the synchroniser when PB_ACTIVE_LOW = 1.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps;
  - tick = 1 for one cycle when the count equals TICK_DIV-1;
  - one prescaler is shared by all channels.
- Debounce, per bit (width clog2(DB_TICKS+1) counter):
  - synced == state: counter cleared every cycle.
  - synced != state, on a tick: counter increments.
  - Counter reaches DB_TICKS on a tick: state flips and counter clears, in the same cycle.
  - A glitch shorter than one tick interval restarts the count.
  - Latency from raw change to output change: SYNC_STAGES + (DB_TICKS-1)*TICK_DIV + 1 cycles minimum, SYNC_STAGES + DB_TICKS*TICK_DIV cycles maximum.
- Edge pulses:
  - PB_Press[i] = 1 in the cycle after IO_PB[i] goes 0->1;
  - PB_Release[i] likewise for 1->0;
  - each pulse lasts exactly 1 cycle;
  - channels are independent; simultaneous edges on several buttons all pulse.
- LEDR: IO_LED_in registered with 1 cycle latency.
- Reset FSM states:
  - POR: after SI_Reset release, count POR_TICKS ticks, then go to RUN.
  - RUN: CPU_Reset_N = 1. A debounced IO_PB[0] = 1 moves the FSM to HOLD.
  - HOLD: CPU_Reset_N = 0. Stays in HOLD while IO_PB[0] = 1. On release, returns to POR, which reloads the stretch count.
  - CPU_Reset_N = 0 in POR and HOLD; it is registered, so it is glitch-free.
- SI_Reset asserted mid-debounce or mid-POR: everything returns to the reset values immediately; no partial state survives.
- Parameter edge cases:
  - TICK_DIV = 1: tick every cycle.
  - DB_TICKS = 1: change after a single mismatching tick.

Optional Feature:
- Macro: MFP_LED_PWM_EN.
- Defined:
  - adds input LED_Bright, width 4;
  - a free-running 4-bit PWM counter increments every cycle;
  - LEDR[i] = IO_LED_in_reg[i] & (pwm_cnt < LED_Bright);
  - LED_Bright = 15 gives 15/16 duty; LED_Bright = 0 gives fully off;
  - pwm_cnt resets to 0.
- Undefined: no LED_Bright port; LEDR = registered IO_LED_in at full on.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV = 4, DB_TICKS = 3, SYNC_STAGES = 2, POR_TICKS = 2.
- Power-up: pulse SI_Reset for 3 cycles, then release. Required: CPU_Reset_N = 0 for 8 cycles ±4 (2 ticks), then 1; IO_Switch = 0.
- Switch debounce: SW_raw[5] goes 0->1 and is held. Required: IO_Switch[5] = 1 between cycles 11 and 14 after the change, never earlier.
- Bounce rejection: toggle SW_raw[2] every 3 cycles for 40 cycles. Required: IO_Switch[2] stays 0.
- Press/release pulses: drive KEY_raw[1] = 0 for 30 cycles, then 1. Required:
  - IO_PB[1] rises;
  - PB_Press[1] pulses for exactly 1 cycle;
  - later, PB_Release[1] pulses for exactly 1 cycle;
  - no pulses on any other bit.
- CPU reset hold: after RUN, hold KEY_raw[0] = 0 for 40 cycles. Required:
  - CPU_Reset_N goes 0 after the debounce latency;
  - after release, CPU_Reset_N stays 0 for the debounce time plus 2 ticks, then goes 1.
- LED and reset mid-operation:
  - LED: IO_LED_in = 18'h2A5A5. Required: LEDR = 18'h2A5A5 one cycle later.
  - Reset mid-operation: assert SI_Reset mid-debounce. Required: all outputs at reset values within the same cycle.
  - With MFP_LED_PWM_EN and LED_Bright = 4: each LED whose registered input is 1 is high 4 of every 16 cycles.
